mole_game_core: RTL
===================

MOLE_GAME_CORE -- requirements
Module: mole_game_core

Interface
REQ-001 SHALL have parameter NUM_HOLES, default 5, number of mole holes/buttons (range 2..16).
REQ-002 SHALL have parameter SCORE_W, default 4, score width; SCORE_MAX = 2^SCORE_W-1.
REQ-003 SHALL have parameter MAX_LIVES, default 3, lives at game start (1..7).
REQ-004 SHALL have parameters UP_TICKS, default 8, and MIN_UP_TICKS, default 2: mole up-time bounds, in ticks.
REQ-005 SHALL have parameter GAP_TICKS, default 2, empty-board ticks between moles.
REQ-006 SHALL have ports: clk in 1, single system clock; rst in 1, synchronous active-high reset.
REQ-007 SHALL have ports: tick in 1, one-clk game-rate enable from a clock divider; start in 1, level; pause in 1, level, toggle on rising edge.
REQ-008 SHALL have port buttons in NUM_HOLES, level, already synchronised, bit i = hole i.
REQ-009 SHALL have outputs: mole_pos out $clog2(NUM_HOLES); mole_valid out 1; score out SCORE_W; lives out 3.
REQ-010 SHALL have outputs: paused, game_lose, game_win (levels); hit_pulse, miss_pulse (one clk).

Function
REQ-011 Button and pause edges SHALL be detected every clk: press = buttons & ~buttons_q; tick gates timers only.
REQ-012 FSM states SHALL be IDLE, GAP, UP, PAUSE, OVER.
REQ-013 IDLE: mole_valid=0; start=1 -> GAP with score=0, lives=MAX_LIVES, gap timer=GAP_TICKS.
REQ-014 GAP: timer decrements on tick; on tick with timer==1 -> UP, mole_pos loaded, up timer loaded.
REQ-015 New mole_pos SHALL be LFSR value mod NUM_HOLES; if equal to previous mole_pos, use (value+1) wrapping at NUM_HOLES.
REQ-016 Up timer load = max(MIN_UP_TICKS, UP_TICKS - (score>>2)), saturating, no underflow.
REQ-017 UP: mole_valid=1; press == one-hot(mole_pos) exactly -> hit: score+1, hit_pulse, -> GAP.
REQ-018 UP: any press bit outside mole_pos (even with the correct bit) -> miss: lives-1, miss_pulse, -> GAP.
REQ-019 UP: tick with up timer==1 and no press -> miss; hit or miss same clk as timeout SHALL take priority, single event only.
REQ-020 Miss with lives==1 -> lives=0, OVER, game_lose=1; hit with score==SCORE_MAX-1 -> score=SCORE_MAX, OVER, game_win=1.
REQ-021 Pause rising edge in GAP/UP -> PAUSE, paused=1, mole_valid=0, timers and score frozen, presses ignored; ignored in IDLE/OVER.
REQ-022 Pause rising edge in PAUSE SHALL return to the saved state with timer and mole_pos unchanged; ticks during PAUSE are lost.
REQ-023 Presses in GAP, IDLE, OVER SHALL have no effect.
REQ-024 OVER: outputs held; start=1 -> clears game_lose/game_win, restarts as REQ-013.
REQ-025 8-bit LFSR (x^8+x^6+x^5+x^4+1) SHALL advance every clk in all states, never all-zero.

Reset
REQ-026 rst=1 at a clk edge SHALL force IDLE from any state, mid-game included.
REQ-027 Reset values: mole_pos=0, mole_valid=0, score=0, lives=MAX_LIVES, paused=0, game_lose=0, game_win=0, pulses=0, timers=0, LFSR=8'hA5, edge registers=0.
REQ-028 A button or pause held high through reset release SHALL NOT register a press.

Structure
REQ-029 Package mole_pkg SHALL hold the state enum, LFSR seed, and LFSR tap constant.
REQ-030 One sub-module mole_lfsr (clk, rst, 8-bit state out) SHALL be instantiated; all else in mole_game_core.

Verification
REQ-031 Defaults, start, wait for mole_valid, press correct hole -> hit_pulse 1 clk, score 0->1, mole_valid 0 next clk.
REQ-032 Mole up, no press for 8 ticks -> miss_pulse, lives 3->2; three timeouts -> lives=0, game_lose=1, OVER.
REQ-033 Mole at hole 2, press buttons=5'b00101 -> miss (not hit), lives-1, score unchanged.
REQ-034 Pause during UP with 5 ticks left, 20 ticks elapse, unpause -> same mole_pos, miss after exactly 5 further ticks.
REQ-035 Score driven to 14, correct hit -> score=15, game_win=1; start -> score=0, lives=3, game_win=0.
REQ-036 rst mid-UP with buttons held high -> IDLE, all outputs at reset values, no hit after release.

Source files
------------

// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole game core: FSM states and the
// 8-bit LFSR constants (x^8+x^6+x^5+x^4+1, Fibonacci form, shifting left).
package mole_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_UP,
    S_PAUSE,
    S_OVER
  } state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 8-bit maximal-length LFSR; a non-zero seed keeps it off the
// all-zero lock-up state.
module mole_lfsr
  import mole_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] state
);

  logic [7:0] r_lfsr;
  logic       w_fb;

  assign w_fb = ^(r_lfsr & LFSR_TAPS);

  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= LFSR_SEED;
    else     r_lfsr <= {r_lfsr[6:0], w_fb};
  end

  assign state = r_lfsr;

endmodule

// File: rtl/mole_game_core.sv
// Whack-a-mole game controller: mole placement, up/gap timing on the game
// tick, hit/miss scoring, lives, pause and win/lose detection.
module mole_game_core
  import mole_pkg::*;
#(
  parameter int NUM_HOLES    = 5,
  parameter int SCORE_W      = 4,
  parameter int MAX_LIVES    = 3,
  parameter int UP_TICKS     = 8,
  parameter int MIN_UP_TICKS = 2,
  parameter int GAP_TICKS    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic                         start,
  input  logic                         pause,
  input  logic [NUM_HOLES-1:0]         buttons,
  output logic [$clog2(NUM_HOLES)-1:0] mole_pos,
  output logic                         mole_valid,
  output logic [SCORE_W-1:0]           score,
  output logic [2:0]                   lives,
  output logic                         paused,
  output logic                         game_lose,
  output logic                         game_win,
  output logic                         hit_pulse,
  output logic                         miss_pulse
);

  localparam int POS_W = $clog2(NUM_HOLES);
  localparam int TMAX0 = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
  localparam int TMAX  = (TMAX0 > MIN_UP_TICKS) ? TMAX0 : MIN_UP_TICKS;
  localparam int TW    = $clog2(TMAX + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t               r_state, r_saved;
  logic [TW-1:0]        r_timer;
  logic [POS_W-1:0]     r_mole_pos;
  logic                 r_mole_valid, r_paused, r_lose, r_win, r_hit, r_miss;
  logic [SCORE_W-1:0]   r_score;
  logic [2:0]           r_lives;
  logic [NUM_HOLES-1:0] r_btn_q;
  logic                 r_pause_q;

  logic [7:0]           w_lfsr;
  logic [NUM_HOLES-1:0] w_press, w_onehot;
  logic                 w_pause_rise;

  mole_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (w_lfsr)
  );

  // Avoid repeating the previous hole so consecutive moles are visibly distinct.
  function automatic logic [POS_W-1:0] pick_pos(input logic [7:0] v,
                                                input logic [POS_W-1:0] prev);
    int p;
    p = int'(v) % NUM_HOLES;
    if (p == int'(prev)) p = (p + 1 == NUM_HOLES) ? 0 : p + 1;
    return POS_W'(p);
  endfunction

  // Moles speed up by one tick every four points, floored at MIN_UP_TICKS.
  function automatic logic [TW-1:0] up_load(input logic [SCORE_W-1:0] s);
    int d;
    d = UP_TICKS - int'(s >> 2);
    if (d < MIN_UP_TICKS) d = MIN_UP_TICKS;
    return TW'(d);
  endfunction

  assign w_press      = buttons & ~r_btn_q;
  assign w_pause_rise = pause & ~r_pause_q;
  assign w_onehot     = {{(NUM_HOLES-1){1'b0}}, 1'b1} << r_mole_pos;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_q   <= '0;
      r_pause_q <= 1'b0;
    end else begin
      r_btn_q   <= buttons;
      r_pause_q <= pause;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_saved      <= S_GAP;
      r_timer      <= '0;
      r_mole_pos   <= '0;
      r_mole_valid <= 1'b0;
      r_score      <= '0;
      r_lives      <= 3'(MAX_LIVES);
      r_paused     <= 1'b0;
      r_lose       <= 1'b0;
      r_win        <= 1'b0;
      r_hit        <= 1'b0;
      r_miss       <= 1'b0;
    end else begin
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
      unique case (r_state)
        S_IDLE, S_OVER: begin
          if (start) begin
            r_state <= S_GAP;
            r_score <= '0;
            r_lives <= 3'(MAX_LIVES);
            r_timer <= TW'(GAP_TICKS);
            r_lose  <= 1'b0;
            r_win   <= 1'b0;
          end
        end
        S_GAP: begin
          if (w_pause_rise) begin
            r_saved  <= S_GAP;
            r_state  <= S_PAUSE;
            r_paused <= 1'b1;
          end else if (tick) begin
            if (r_timer <= TW'(1)) begin
              r_state      <= S_UP;
              r_mole_valid <= 1'b1;
              r_mole_pos   <= pick_pos(w_lfsr, r_mole_pos);
              r_timer      <= up_load(r_score);
            end else begin
              r_timer <= r_timer - 1'b1;
            end
          end
        end
        S_UP: begin
          if (w_pause_rise) begin
            r_saved      <= S_UP;
            r_state      <= S_PAUSE;
            r_paused     <= 1'b1;
            r_mole_valid <= 1'b0;
          end else if ((|w_press) || (tick && r_timer <= TW'(1))) begin
            // A press always resolves the mole; a bare timeout is a miss.
            r_mole_valid <= 1'b0;
            r_timer      <= TW'(GAP_TICKS);
            if (w_press == w_onehot) begin
              r_hit <= 1'b1;
              if (r_score == SCORE_MAX - 1'b1) begin
                r_score <= SCORE_MAX;
                r_state <= S_OVER;
                r_win   <= 1'b1;
              end else begin
                r_score <= r_score + 1'b1;
                r_state <= S_GAP;
              end
            end else begin
              r_miss <= 1'b1;
              if (r_lives <= 3'd1) begin
                r_lives <= 3'd0;
                r_state <= S_OVER;
                r_lose  <= 1'b1;
              end else begin
                r_lives <= r_lives - 3'd1;
                r_state <= S_GAP;
              end
            end
          end else if (tick) begin
            r_timer <= r_timer - 1'b1;
          end
        end
        S_PAUSE: begin
          if (w_pause_rise) begin
            r_state      <= r_saved;
            r_paused     <= 1'b0;
            r_mole_valid <= (r_saved == S_UP);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mole_pos   = r_mole_pos;
  assign mole_valid = r_mole_valid;
  assign score      = r_score;
  assign lives      = r_lives;
  assign paused     = r_paused;
  assign game_lose  = r_lose;
  assign game_win   = r_win;
  assign hit_pulse  = r_hit;
  assign miss_pulse = r_miss;

endmodule
